// File: rtl/axi_dut_slave.sv
// AXI4 slave backed by a small byte-addressed memory.
// Supports FIXED/INCR/WRAP bursts with strobes, one outstanding transaction per direction.
module axi_dut_slave #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic unused_sigs;
  assign unused_sigs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot};

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0]        len,
                                                  input logic [2:0]        size,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] bytes, inc, total, lower;
    bytes = (size > 3'd2) ? ADDR_W'(4) : (ADDR_W'(1) << size);
    inc   = addr + bytes;
    total = bytes * (ADDR_W'(len) + ADDR_W'(1));
    // total is a power of two for the legal wrap lengths, so masking gives the boundary
    lower = addr & ~(total - ADDR_W'(1));
    case (burst)
      2'b01:   next_addr = inc;
      2'b10: begin
        if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) begin
          next_addr = (inc == lower + total) ? lower : inc;
        end else begin
          next_addr = inc;
        end
      end
      default: next_addr = addr;
    endcase
  endfunction

  logic [8*MEM_BYTES-1:0] mem_q, mem_d;

  // Write channel state
  w_state_e          w_state_q;
  logic [ID_W-1:0]   bid_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [7:0]        w_len_q, w_cnt_q;
  logic [2:0]        w_size_q;
  logic [1:0]        w_burst_q, bresp_q;
  logic              w_err_q, awready_q, wready_q, bvalid_q;

  logic [ADDR_W-1:0] w_base;
  logic              w_fire, w_last_beat, w_beat_err;

  always_comb begin
    w_base      = {w_addr_q[ADDR_W-1:2], 2'b00};
    w_fire      = (w_state_q == WData) && s_axi_wvalid && wready_q;
    w_last_beat = (w_cnt_q == w_len_q);
    w_beat_err  = (w_burst_q == BURST_RSVD) || (s_axi_wlast != w_last_beat);
    mem_d       = mem_q;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (s_axi_wstrb[i]) begin
        if ((w_base + ADDR_W'(i)) >= MEM_LIMIT) begin
          w_beat_err = 1'b1;
        end else if (w_fire && w_burst_q != BURST_RSVD) begin
          mem_d[8*(int'(w_base[IDX_W-1:0]) + i) +: 8] = s_axi_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= WIdle;
      bid_q     <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      bresp_q   <= RESP_OKAY;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      case (w_state_q)
        WIdle: begin
          if (!awready_q) begin
            awready_q <= 1'b1;
          end else if (s_axi_awvalid) begin
            bid_q     <= s_axi_awid;
            w_addr_q  <= s_axi_awaddr;
            w_len_q   <= s_axi_awlen;
            w_size_q  <= s_axi_awsize;
            w_burst_q <= s_axi_awburst;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= WData;
          end
        end
        WData: begin
          if (w_fire) begin
            w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
            w_cnt_q  <= w_cnt_q + 8'd1;
            w_err_q  <= w_err_q | w_beat_err;
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= WResp;
            end
          end
        end
        WResp: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Read channel state
  r_state_e          r_state_q;
  logic [ID_W-1:0]   rid_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic [7:0]        r_len_q, r_cnt_q;
  logic [2:0]        r_size_q;
  logic [1:0]        r_burst_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic              arready_q, rvalid_q, rlast_q;

  logic [ADDR_W-1:0] r_sel_addr, r_base;
  logic [1:0]        r_sel_burst;
  logic [DATA_W-1:0] r_word;
  logic              r_err;

  // In idle the beat-0 word comes from araddr; otherwise it is the next burst address
  always_comb begin
    if (r_state_q == RIdle) begin
      r_sel_addr  = s_axi_araddr;
      r_sel_burst = s_axi_arburst;
    end else begin
      r_sel_addr  = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
      r_sel_burst = r_burst_q;
    end
    r_base = {r_sel_addr[ADDR_W-1:2], 2'b00};
    r_err  = (r_base >= MEM_LIMIT) || (r_sel_burst == BURST_RSVD);
    r_word = '0;
    if (!r_err) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        r_word[8*i +: 8] = mem_q[8*(int'(r_base[IDX_W-1:0]) + i) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= RIdle;
      rid_q     <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      case (r_state_q)
        RIdle: begin
          if (!arready_q) begin
            arready_q <= 1'b1;
          end else if (s_axi_arvalid) begin
            rid_q     <= s_axi_arid;
            r_addr_q  <= s_axi_araddr;
            r_len_q   <= s_axi_arlen;
            r_size_q  <= s_axi_arsize;
            r_burst_q <= s_axi_arburst;
            r_cnt_q   <= '0;
            rdata_q   <= r_word;
            rresp_q   <= r_err ? RESP_SLVERR : RESP_OKAY;
            rlast_q   <= (s_axi_arlen == 8'd0);
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            r_state_q <= RData;
          end
        end
        RData: begin
          if (s_axi_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rdata_q   <= '0;
              rresp_q   <= RESP_OKAY;
              arready_q <= 1'b1;
              r_state_q <= RIdle;
            end else begin
              r_addr_q <= r_sel_addr;
              r_cnt_q  <= r_cnt_q + 8'd1;
              rdata_q  <= r_word;
              rresp_q  <= r_err ? RESP_SLVERR : RESP_OKAY;
              rlast_q  <= ((r_cnt_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi_dut_slave.sv
// Directed bench for axi_dut_slave: expected B and R responses are queued as stimulus is
// issued and compared as the DUT returns them.
module tb_axi_dut_slave;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awlock, s_axi_arlock;
  logic [3:0]  s_axi_awcache, s_axi_arcache, s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  r_exp_t      r_exp_q[$];
  logic [5:0]  b_exp_q[$];
  logic [31:0] w_data_q[$];
  logic [3:0]  w_strb_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_dut_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [31:0] data, input logic [3:0] strb);
    w_data_q.push_back(data);
    w_strb_q.push_back(strb);
  endtask

  task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                        input logic last);
    r_exp_q.push_back('{id: id, data: data, resp: resp, last: last});
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int bdelay);
    int n;
    logic [5:0] eb;
    eb = b_exp_q.pop_front();
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = 3'd2; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (s_axi_awready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
    check("aw_handshake_in_time", 64'(n < TMO), 64'(1));
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_axi_wdata  = w_data_q.pop_front();
      s_axi_wstrb  = w_strb_q.pop_front();
      s_axi_wlast  = (b == int'(len));
      s_axi_wvalid = 1'b1;
      n = 0;
      while (s_axi_wready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
      check("w_handshake_in_time", 64'(n < TMO), 64'(1));
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check("bvalid_after_last_w", 64'(s_axi_bvalid), 64'(1));
    for (int i = 0; i < bdelay; i++) begin
      check("b_hold_stable", {s_axi_bvalid, s_axi_bid, s_axi_bresp}, {1'b1, eb});
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b1;
    n = 0;
    while (s_axi_bvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
    check("bid_bresp", {s_axi_bid, s_axi_bresp}, 64'(eb));
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check("awready_after_b", {s_axi_bvalid, s_axi_awready}, 64'(2'b01));
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit toggle);
    int n, beats, cyc;
    r_exp_t e;
    logic        held;
    logic [34:0] held_val;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = 3'd2; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (s_axi_arready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
    check("ar_handshake_in_time", 64'(n < TMO), 64'(1));
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    check("rvalid_after_ar", 64'(s_axi_rvalid), 64'(1));
    beats = 0; cyc = 0; held = 1'b0; held_val = '0;
    while (beats <= int'(len) && cyc < TMO) begin
      if (held) check("r_stable_when_stalled", {s_axi_rdata, s_axi_rresp, s_axi_rlast}, held_val);
      s_axi_rready = toggle ? (cyc % 3 != 1) : 1'b1;
      if (s_axi_rvalid === 1'b1 && s_axi_rready) begin
        e = r_exp_q.pop_front();
        check("rid", 64'(s_axi_rid), 64'(e.id));
        check("rdata", 64'(s_axi_rdata), 64'(e.data));
        check("rresp", 64'(s_axi_rresp), 64'(e.resp));
        check("rlast", 64'(s_axi_rlast), 64'(e.last));
        beats++;
      end
      held     = (s_axi_rvalid === 1'b1) && !s_axi_rready;
      held_val = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
      @(posedge clk); #1;
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("r_beat_count", 64'(beats), 64'(int'(len) + 1));
    check("r_idle_after_last", {s_axi_rvalid, s_axi_arready}, 64'(2'b01));
  endtask

  initial begin
    rst = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs_zero",
          {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp, s_axi_arready,
           s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {s_axi_awready, s_axi_arready}, 64'(2'b11));

    push_r(4'h1, 32'h0, OKAY, 1'b1);
    axi_read(4'h1, 32'h0, 8'd0, INCR, 1'b0);

    // INCR write then read back
    push_w(32'd1, 4'hF); push_w(32'd2, 4'hF); push_w(32'd3, 4'hF); push_w(32'd4, 4'hF);
    b_exp_q.push_back({4'h5, OKAY});
    axi_write(4'h5, 32'h10, 8'd3, INCR, 0);
    push_r(4'h3, 32'd1, OKAY, 1'b0); push_r(4'h3, 32'd2, OKAY, 1'b0);
    push_r(4'h3, 32'd3, OKAY, 1'b0); push_r(4'h3, 32'd4, OKAY, 1'b1);
    axi_read(4'h3, 32'h10, 8'd3, INCR, 1'b0);

    // WRAP write from 0x0C lands at 0x0C,0x00,0x04,0x08
    push_w(32'hA, 4'hF); push_w(32'hB, 4'hF); push_w(32'hC, 4'hF); push_w(32'hD, 4'hF);
    b_exp_q.push_back({4'h6, OKAY});
    axi_write(4'h6, 32'h0C, 8'd3, WRAP, 0);
    push_r(4'h7, 32'hB, OKAY, 1'b0); push_r(4'h7, 32'hC, OKAY, 1'b0);
    push_r(4'h7, 32'hD, OKAY, 1'b0); push_r(4'h7, 32'hA, OKAY, 1'b1);
    axi_read(4'h7, 32'h00, 8'd3, INCR, 1'b0);
    push_r(4'h8, 32'hA, OKAY, 1'b0); push_r(4'h8, 32'hB, OKAY, 1'b0);
    push_r(4'h8, 32'hC, OKAY, 1'b0); push_r(4'h8, 32'hD, OKAY, 1'b1);
    axi_read(4'h8, 32'h0C, 8'd3, WRAP, 1'b0);

    // FIXED burst merging two strobed halves
    push_w(32'h11223344, 4'h3); push_w(32'hAABBCCDD, 4'hC);
    b_exp_q.push_back({4'h2, OKAY});
    axi_write(4'h2, 32'h20, 8'd1, FIXED, 0);
    push_r(4'h2, 32'hAABB3344, OKAY, 1'b1);
    axi_read(4'h2, 32'h20, 8'd0, INCR, 1'b0);

    // Out of range: no aliasing into low memory
    push_w(32'hDEADBEEF, 4'hF);
    b_exp_q.push_back({4'h9, SLVERR});
    axi_write(4'h9, 32'h80, 8'd0, INCR, 0);
    push_r(4'h9, 32'h0, SLVERR, 1'b1);
    axi_read(4'h9, 32'h80, 8'd0, INCR, 1'b0);
    push_r(4'h4, 32'hB, OKAY, 1'b1);
    axi_read(4'h4, 32'h00, 8'd0, INCR, 1'b0);

    // Reserved burst: error response, memory untouched
    push_w(32'h55, 4'hF);
    b_exp_q.push_back({4'hC, SLVERR});
    axi_write(4'hC, 32'h30, 8'd0, RSVD, 0);
    push_r(4'hC, 32'h0, OKAY, 1'b1);
    axi_read(4'hC, 32'h30, 8'd0, INCR, 1'b0);

    // B backpressure, then R backpressure with toggled rready
    push_w(32'h12345678, 4'hF);
    b_exp_q.push_back({4'hD, OKAY});
    axi_write(4'hD, 32'h40, 8'd0, INCR, 4);
    push_r(4'hD, 32'h12345678, OKAY, 1'b1);
    axi_read(4'hD, 32'h40, 8'd0, INCR, 1'b0);
    push_r(4'hE, 32'd1, OKAY, 1'b0); push_r(4'hE, 32'd2, OKAY, 1'b0);
    push_r(4'hE, 32'd3, OKAY, 1'b0); push_r(4'hE, 32'd4, OKAY, 1'b1);
    axi_read(4'hE, 32'h10, 8'd3, INCR, 1'b1);

    // Concurrent write and read bursts on disjoint addresses
    push_w(32'hA0, 4'hF); push_w(32'hA1, 4'hF); push_w(32'hA2, 4'hF); push_w(32'hA3, 4'hF);
    b_exp_q.push_back({4'hA, OKAY});
    push_r(4'hB, 32'd1, OKAY, 1'b0); push_r(4'hB, 32'd2, OKAY, 1'b0);
    push_r(4'hB, 32'd3, OKAY, 1'b0); push_r(4'hB, 32'd4, OKAY, 1'b1);
    fork
      axi_write(4'hA, 32'h50, 8'd3, INCR, 0);
      axi_read(4'hB, 32'h10, 8'd3, INCR, 1'b0);
    join
    push_r(4'hF, 32'hA0, OKAY, 1'b0); push_r(4'hF, 32'hA1, OKAY, 1'b0);
    push_r(4'hF, 32'hA2, OKAY, 1'b0); push_r(4'hF, 32'hA3, OKAY, 1'b1);
    axi_read(4'hF, 32'h50, 8'd3, INCR, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_dut_slave.md
# axi_dut_slave

AXI4 slave with a small on-chip byte-addressed memory. It accepts bursts on independent write (AW/W/B) and read (AR/R) channels and supports FIXED, INCR and WRAP bursts with byte strobes. It is the device under test of the AXI verification environment, where the `axi_if` interface and `axi_program` stimulus program drive it directly.

## Interface
Parameters:
- ID_W, 4, transaction ID width
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed; STRB = 4 bits)
- MEM_BYTES, 128, memory size in bytes; valid addresses are 0..MEM_BYTES-1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address fields
- s_axi_awlock/awcache/awprot  in  1/4/3  accepted, ignored
- s_axi_awvalid  in  1;  s_axi_awready  out  1
- s_axi_wdata/wstrb/wlast/wvalid  in  32/4/1/1;  s_axi_wready  out  1
- s_axi_bid  out  ID_W;  s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2;  s_axi_arlock/arcache/arprot  in  1/4/3 (ignored)
- s_axi_arvalid  in  1;  s_axi_arready  out  1
- s_axi_rid  out  ID_W;  s_axi_rdata  out  32;  s_axi_rresp  out  2;  s_axi_rlast  out  1;  s_axi_rvalid  out  1;  s_axi_rready  in  1

## Operation
- Reset (rst=0): all outputs 0; memory cleared to 0; both FSMs go to IDLE.
- Write FSM states: IDLE, DATA, RESP.
  - IDLE: awready=1. On awvalid&&awready, latch id, addr, len, size, burst; clear error flag; go to DATA.
  - DATA: wready=1. For each wvalid&&wready beat, write every byte lane i with wstrb[i]=1 to mem[(addr & ~3) + i]. A lane whose address is >= MEM_BYTES is dropped and sets the error flag. After the beat, advance the address and count beats.
  - The burst ends on beat awlen+1. If wlast disagrees with the beat count on any beat, set the error flag. Then go to RESP.
  - RESP: bvalid=1, bid=latched awid, bresp=OKAY(00), or SLVERR(10) if the error flag is set. Hold the response until bready, then return to IDLE.
- Read FSM states: IDLE, DATA.
  - IDLE: arready=1. On handshake, latch fields, load beat 0 and go to DATA.
  - DATA: rvalid=1, rid=latched arid, rdata=32-bit word at addr & ~3 (byte i = mem[(addr & ~3)+i]), rresp=OKAY, or SLVERR with rdata=0 if that address is out of range. rlast=1 on beat arlen.
  - On rvalid&&rready: if it was the last beat, return to IDLE; otherwise load the next beat.
- Address sequencing (bytes = 1<<size; size>2 treated as 2):
  - FIXED (00): address constant.
  - INCR (01): addr += bytes.
  - WRAP (10): total = bytes*(len+1); lower = addr - (addr mod total). Next = addr+bytes, or lower when it reaches lower+total. The len must be 1/3/7/15; any other len is treated as INCR.
  - Reserved (11): treated as FIXED, and every beat of that burst responds SLVERR. Reserved writes do not modify memory.
- One outstanding transaction per direction. The read and write channels operate fully concurrently. A read and a write to the same byte in the same cycle returns the old data.

## Timing
- AW handshake at edge N → wready=1 from cycle N+1; awready=0 until the FSM returns to IDLE.
- W beats are accepted every cycle while wvalid=1. Last W handshake at edge M → bvalid=1 in cycle M+1.
- B handshake at edge K → awready=1 in cycle K+1.
- AR handshake at edge N → rvalid=1 with beat 0 in cycle N+1.
- With rready held high, one beat per cycle, no bubbles. rdata/rresp/rlast stay stable while rvalid=1 and rready=0.
- Last R handshake at edge K → rvalid=0, arready=1 in cycle K+1.
- Reset mid-burst aborts both FSMs immediately. Partially written bytes keep their values until the reset clears memory.

## Test plan
- Reset: hold rst=0 for 5 cycles → all outputs 0. Release → awready=arready=1 on the next cycle. Read of addr 0x0 → rdata 0x00000000, OKAY.
- INCR write: awaddr 0x10, len 3, size 2, data 1,2,3,4, strb F → bresp OKAY, bid=awid. Then INCR read from 0x10, len 3 → rdata 1,2,3,4 with rlast on beat 4 only.
- WRAP: write 0x0C, len 3, size 2, data A,B,C,D → bytes land at 0x0C,0x00,0x04,0x08. WRAP read from 0x0C returns A,B,C,D.
- FIXED with strobes: write 0x20, len 1, data 0x11223344 strb 0x3, then 0xAABBCCDD strb 0xC → read 0x20 returns 0xAABB3344.
- Out of range: write 0x80, len 0 → bresp SLVERR, memory unchanged. Read 0x80 → rdata 0, rresp SLVERR.
- Backpressure and concurrency: hold bready=0 for 4 cycles → bvalid and bresp remain stable. Toggle rready mid-burst → no beat is lost or duplicated. A simultaneous write and read burst on disjoint addresses both complete correctly.
